// File: rtl/clk_div_pkg.sv
// Shared types for the slow-clock divider arbiter: FSM states, pick result, round-robin search.
// Pure declarations and combinational helpers; no state, no latency.
package clk_div_pkg;

   localparam int M_W     = 32;
   localparam int MAX_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SWITCH = 2'd1,
      RUN    = 2'd2
   } state_t;

   typedef struct packed {
      logic             vld;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // Unused upper request bits are zero, so a modulo-8 walk is the same as a modulo-N_REQ walk
   // provided ptr < N_REQ.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req, input logic [IDX_W-1:0] ptr);
      pick_t            p;
      logic [IDX_W-1:0] k;
      p = '0;
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         k = ptr + IDX_W'(i);
         if (req[k]) begin
            p.vld = 1'b1;
            p.idx = k;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/clk_div_core.sv
// Programmable divider: SLOW_CLOCK toggles whenever the count is zero, period 2*(m+1) cycles.
// clear wins over run and zeroes count and output on the next edge; tick flags a count-zero run cycle.
module clk_div_core
   import clk_div_pkg::*;
(
   input  logic           CLOCK,
   input  logic           clear,
   input  logic           run,
   input  logic [M_W-1:0] m,
   output logic           SLOW_CLOCK,
   output logic           tick
);

   logic [M_W-1:0] count;

   assign tick = run && (count == '0);

   always_ff @(posedge CLOCK) begin
      if (clear) begin
         count      <= '0;
         SLOW_CLOCK <= 1'b0;
      end else if (run) begin
         count <= (count == m) ? '0 : count + M_W'(1);
         if (count == '0) begin
            SLOW_CLOCK <= ~SLOW_CLOCK;
         end
      end
   end

endmodule

// File: rtl/clock_divider_arbiter.sv
// Round-robin owner of one slow-clock divider; REQ in IDLE at edge t gives GRANT/M_ACTIVE at t+1
// and the first SLOW_CLOCK rise at t+2. Owners hold the divider for SLOT_TOGGLES toggles before preemption.
module clock_divider_arbiter
   import clk_div_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int SLOT_TOGGLES = 16
) (
   input  logic                 CLOCK,
   input  logic                 RESET,
   input  logic [N_REQ-1:0]     REQ,
   input  logic [M_W*N_REQ-1:0] M_IN,
   output logic [N_REQ-1:0]     GRANT,
   output logic [M_W-1:0]       M_ACTIVE,
   output logic                 SLOW_CLOCK,
   output logic                 BUSY
);

   localparam int TC_W = $clog2(SLOT_TOGGLES + 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] ptr, nxt;
   logic [TC_W-1:0]  toggle_cnt;
   pick_t            pick;
   logic             tick, own_req, other_req;
   logic             release_hit, preempt_hit;
   logic             core_clear, core_run;
   logic [M_W-1:0]   m_sel;
   logic [N_REQ-1:0] grant_sel;

   always_comb begin
      pick        = rr_pick(MAX_REQ'(REQ), ptr);
      own_req     = |(REQ & GRANT);
      other_req   = |(REQ & ~GRANT);
      state_nxt   = state;
      release_hit = 1'b0;
      preempt_hit = 1'b0;
      case (state)
         IDLE: begin
            if (pick.vld) state_nxt = SWITCH;
         end
         SWITCH: begin
            state_nxt = RUN;
         end
         RUN: begin
            // Release is checked first so it overrides a coincident preemption.
            if (!own_req) begin
               release_hit = 1'b1;
               state_nxt   = pick.vld ? SWITCH : IDLE;
            end else if (tick && (toggle_cnt == TC_W'(SLOT_TOGGLES)) && other_req) begin
               preempt_hit = 1'b1;
               state_nxt   = SWITCH;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      core_run   = (state == RUN);
      core_clear = RESET || (state != RUN) || release_hit || preempt_hit;
   end

   always_comb begin
      m_sel     = '0;
      grant_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (nxt == IDX_W'(i)) begin
            m_sel        = M_IN[i*M_W +: M_W];
            grant_sel[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         GRANT      <= '0;
         M_ACTIVE   <= '0;
         ptr        <= '0;
         nxt        <= '0;
         toggle_cnt <= '0;
      end else begin
         if ((state != SWITCH) && (state_nxt == SWITCH)) begin
            nxt <= pick.idx;
         end
         if (state == SWITCH) begin
            GRANT      <= grant_sel;
            M_ACTIVE   <= m_sel;
            toggle_cnt <= '0;
            ptr        <= (nxt == IDX_W'(N_REQ - 1)) ? '0 : nxt + 1'b1;
         end else if (release_hit) begin
            GRANT <= '0;
         end else if (core_run && tick && !preempt_hit &&
                      (toggle_cnt != TC_W'(SLOT_TOGGLES))) begin
            toggle_cnt <= toggle_cnt + 1'b1;
         end
      end
   end

   assign BUSY = (state != IDLE);

   clk_div_core u_core (
      .CLOCK      (CLOCK),
      .clear      (core_clear),
      .run        (core_run),
      .m          (M_ACTIVE),
      .SLOW_CLOCK (SLOW_CLOCK),
      .tick       (tick)
   );

endmodule

// File: tb/tb_clock_divider_arbiter.sv
// Directed bench for clock_divider_arbiter with N_REQ=4, SLOT_TOGGLES=4.
module tb_clock_divider_arbiter;

   logic         CLOCK;
   logic         RESET;
   logic [3:0]   REQ;
   logic [127:0] M_IN;
   logic [3:0]   GRANT;
   logic [31:0]  M_ACTIVE;
   logic         SLOW_CLOCK;
   logic         BUSY;
   logic [31:0]  m [4];

   int checks = 0;
   int errors = 0;

   assign M_IN = {m[3], m[2], m[1], m[0]};

   clock_divider_arbiter #(.N_REQ(4), .SLOT_TOGGLES(4)) dut (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .REQ        (REQ),
      .M_IN       (M_IN),
      .GRANT      (GRANT),
      .M_ACTIVE   (M_ACTIVE),
      .SLOW_CLOCK (SLOW_CLOCK),
      .BUSY       (BUSY)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      RESET = 1'b1;
      REQ   = 4'b0000;
      for (int i = 0; i < 4; i++) m[i] = 32'd0;
      step();
      step();
      RESET = 1'b0;
      chk("rst_grant", 32'(GRANT), 32'h0);
      chk("rst_mact", M_ACTIVE, 32'h0);
      chk("rst_slow", 32'(SLOW_CLOCK), 32'h0);
      chk("rst_busy", 32'(BUSY), 32'h0);

      // Sole requester 0 with m=3: period 8, first rise two edges after SWITCH.
      m[0] = 32'd3;
      REQ  = 4'b0001;
      step();
      chk("t1_busy_sw", 32'(BUSY), 32'h1);
      chk("t1_grant_sw", 32'(GRANT), 32'h0);
      step();
      chk("t1_grant", 32'(GRANT), 32'h1);
      chk("t1_mact", M_ACTIVE, 32'd3);
      chk("t1_slow_lo", 32'(SLOW_CLOCK), 32'h0);
      step();
      chk("t1_rise", 32'(SLOW_CLOCK), 32'h1);
      for (int k = 3; k <= 14; k++) begin
         step();
         chk("t1_div", 32'(SLOW_CLOCK), ((((k - 2) / 4) % 2) == 0) ? 32'h1 : 32'h0);
      end

      // M_IN change during RUN is ignored until the next SWITCH.
      m[0] = 32'd9;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("mchg_hold", M_ACTIVE, 32'd3);
      end
      REQ = 4'b0000;
      step();
      chk("rel_grant", 32'(GRANT), 32'h0);
      chk("rel_slow", 32'(SLOW_CLOCK), 32'h0);
      chk("rel_busy", 32'(BUSY), 32'h0);
      REQ = 4'b0001;
      step();
      step();
      chk("mchg_grant", 32'(GRANT), 32'h1);
      chk("mchg_new", M_ACTIVE, 32'd9);

      // Reset mid-RUN with owner 1 (ptr would otherwise be 2).
      REQ = 4'b0000;
      step();
      m[1] = 32'd7;
      REQ  = 4'b0010;
      step();
      step();
      chk("r_grant", 32'(GRANT), 32'h2);
      chk("r_mact", M_ACTIVE, 32'd7);
      step();
      chk("r_slow_hi", 32'(SLOW_CLOCK), 32'h1);
      RESET = 1'b1;
      step();
      chk("r_grant0", 32'(GRANT), 32'h0);
      chk("r_mact0", M_ACTIVE, 32'h0);
      chk("r_slow0", 32'(SLOW_CLOCK), 32'h0);
      chk("r_busy0", 32'(BUSY), 32'h0);
      RESET = 1'b0;
      REQ   = 4'b1001;
      step();
      chk("r_busy_sw", 32'(BUSY), 32'h1);
      step();
      chk("r_ptr0", 32'(GRANT), 32'h1);

      // Two requesters alternate after SLOT_TOGGLES=4 toggles each.
      REQ = 4'b0000;
      step();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      m[0] = 32'd1;
      m[1] = 32'd5;
      REQ  = 4'b0011;
      step();
      chk("a_busy", 32'(BUSY), 32'h1);
      step();
      chk("a_grant0", 32'(GRANT), 32'h1);
      chk("a_mact0", M_ACTIVE, 32'd1);
      step();
      chk("a_rise0", 32'(SLOW_CLOCK), 32'h1);
      repeat (7) step();
      chk("a_slow9", 32'(SLOW_CLOCK), 32'h0);
      chk("a_grant9", 32'(GRANT), 32'h1);
      step();
      chk("a_pre_slow", 32'(SLOW_CLOCK), 32'h0);
      chk("a_pre_busy", 32'(BUSY), 32'h1);
      step();
      chk("a_grant1", 32'(GRANT), 32'h2);
      chk("a_mact1", M_ACTIVE, 32'd5);
      chk("a_gap_slow", 32'(SLOW_CLOCK), 32'h0);
      step();
      chk("a_rise1", 32'(SLOW_CLOCK), 32'h1);
      repeat (24) step();
      chk("a_pre2_slow", 32'(SLOW_CLOCK), 32'h0);
      chk("a_pre2_grant", 32'(GRANT), 32'h2);
      step();
      chk("a_back0", 32'(GRANT), 32'h1);
      chk("a_back0_m", M_ACTIVE, 32'd1);

      // Owner 2 releases mid-high phase while requester 3 waits.
      REQ = 4'b0000;
      step();
      m[2] = 32'd3;
      m[3] = 32'd2;
      REQ  = 4'b1100;
      step();
      step();
      chk("d_grant2", 32'(GRANT), 32'h4);
      step();
      step();
      chk("d_high", 32'(SLOW_CLOCK), 32'h1);
      REQ = 4'b1000;
      step();
      chk("d_slow0", 32'(SLOW_CLOCK), 32'h0);
      chk("d_grant0", 32'(GRANT), 32'h0);
      chk("d_busy", 32'(BUSY), 32'h1);
      step();
      chk("d_grant3", 32'(GRANT), 32'h8);
      chk("d_mact3", M_ACTIVE, 32'd2);

      // Sole requester with m=0 toggles every cycle and is never regranted.
      REQ = 4'b0000;
      step();
      m[1] = 32'd0;
      REQ  = 4'b0010;
      step();
      step();
      chk("z_grant", 32'(GRANT), 32'h2);
      for (int k = 0; k < 100; k++) begin
         step();
         chk("z_slow", 32'(SLOW_CLOCK), ((k % 2) == 0) ? 32'h1 : 32'h0);
         chk("z_grant_stable", 32'(GRANT), 32'h2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
